// File: rtl/mv_stream_driver.sv
// ============================================================================
// mv_stream_driver : word-serial initiator for the mul4x4_4x1 accelerator.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mv_stream_driver #(
  parameter int TIMEOUT = 1024
) (
  input  logic        iClk,
  input  logic        iRstn,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  input  logic [1:0]  res_addr,
  output logic [31:0] res_data,
  input  logic        ready,
  output logic        data_valid,
  output logic [31:0] data,
  input  logic        data_done,
  input  logic        calc_done,
  input  logic [31:0] result,
  output logic        read_done
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND    = 3'd1,
    WAIT_DD = 3'd2,
    CAPTURE = 3'd3,
    ACK     = 3'd4,
    RELEASE = 3'd5,
    FINISH  = 3'd6
  } state_t;

  state_t         state;
  logic [4:0]     send_idx;
  logic [2:0]     res_idx;
  logic [CW-1:0]  tmo_cnt;
  logic [31:0]    opfile [20];
  logic [31:0]    res_q  [4];
  logic           stall;
  logic           tmo_hit;

  // The operand file is read live so a write coinciding with start is the word sent.
  assign data     = data_valid ? opfile[send_idx] : '0;
  assign res_data = res_q[res_addr];
  assign tmo_hit  = (tmo_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    stall = 1'b0;
    case (state)
      SEND:    stall = !ready;
      WAIT_DD: stall = !data_done;
      CAPTURE: stall = !calc_done;
      RELEASE: stall = calc_done;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      for (int i = 0; i < 20; i++) opfile[i] <= '0;
    end else if (wr_en && !busy && (wr_addr < 5'd20)) begin
      opfile[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state      <= IDLE;
      send_idx   <= '0;
      res_idx    <= '0;
      tmo_cnt    <= '0;
      data_valid <= 1'b0;
      read_done  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      for (int i = 0; i < 4; i++) res_q[i] <= '0;
    end else begin
      read_done <= 1'b0;
      done      <= 1'b0;
      if (stall && tmo_hit) begin
        error      <= 1'b1;
        data_valid <= 1'b0;
        busy       <= 1'b0;
        done       <= 1'b1;
        tmo_cnt    <= '0;
        state      <= FINISH;
      end else if (stall) begin
        tmo_cnt <= tmo_cnt + CW'(1);
      end else begin
        case (state)
          IDLE: begin
            send_idx <= '0;
            res_idx  <= '0;
            tmo_cnt  <= '0;
            if (start) begin
              error      <= 1'b0;
              busy       <= 1'b1;
              data_valid <= 1'b1;
              state      <= SEND;
            end
          end
          SEND: begin
            tmo_cnt <= '0;
            if (send_idx == 5'd19) begin
              data_valid <= 1'b0;
              state      <= WAIT_DD;
            end else begin
              send_idx <= send_idx + 5'd1;
            end
          end
          WAIT_DD: begin
            tmo_cnt <= '0;
            state   <= CAPTURE;
          end
          CAPTURE: begin
            res_q[res_idx[1:0]] <= result;
            read_done           <= 1'b1;
            tmo_cnt             <= '0;
            state               <= ACK;
          end
          ACK: begin
            res_idx <= res_idx + 3'd1;
            state   <= RELEASE;
          end
          RELEASE: begin
            // Leaving only after calc_done drops keeps one result from being taken twice.
            tmo_cnt <= '0;
            if (res_idx < 3'd4) begin
              state <= CAPTURE;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FINISH;
            end
          end
          FINISH:  state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mv_stream_driver.sv
// ============================================================================
// tb_mv_stream_driver : randomized self-checking bench with an accelerator model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mv_stream_driver;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, start, ready, data_done, calc_done;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data, result;
  logic [1:0]  res_addr;
  logic        busy, done, error, data_valid, read_done;
  logic [31:0] res_data, data;

  always #5 clk = ~clk;

  mv_stream_driver #(.TIMEOUT(TMO)) dut (
    .iClk(clk), .iRstn(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .done(done), .error(error), .res_addr(res_addr),
    .res_data(res_data), .ready(ready), .data_valid(data_valid), .data(data),
    .data_done(data_done), .calc_done(calc_done), .result(result), .read_done(read_done)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] op_model  [20];
  logic [31:0] res_model [4];
  logic [31:0] res_send  [4];
  logic [31:0] got[$];
  int          acc_cyc[$];
  int          rd_cnt, done_cnt, done_cyc;
  logic        dv_at21, busy_at1, err_at1, busy_at_done, err_at_done;
  bit          finished;

  task automatic idle_inputs;
    wr_en = 0; start = 0; ready = 0; data_done = 0; calc_done = 0;
  endtask

  task automatic write_word(input logic [4:0] a, input logic [31:0] v);
    @(negedge clk);
    wr_en = 1; wr_addr = a; wr_data = v;
    if (a < 5'd20) op_model[a] = v;
  endtask

  // Host + accelerator model for one transaction. Inputs change on negedges only.
  task automatic run_txn(input int rmode, input int hold, input bit no_dd, input int abort_after,
                         input int poke_cyc, input bit wr_start);
    int phase, k, hold_left, gap, low_run;
    got.delete(); acc_cyc.delete();
    rd_cnt = 0; done_cnt = 0; done_cyc = -1; finished = 0;
    dv_at21 = 1'bx; busy_at1 = 1'bx; err_at1 = 1'bx; busy_at_done = 1'bx; err_at_done = 1'bx;
    @(negedge clk);
    idle_inputs();
    start = 1;
    if (wr_start) begin
      wr_en = 1; wr_addr = 5'($urandom_range(0, 19)); wr_data = $urandom;
      op_model[wr_addr] = wr_data;
    end
    phase = 0; k = 0; hold_left = 0; gap = 0; low_run = 0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      start = 0; wr_en = 0; data_done = 0;
      if (read_done) rd_cnt++;
      if (cyc == 1) begin busy_at1 = busy; err_at1 = error; end
      if (cyc == 21) dv_at21 = data_valid;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = cyc; busy_at_done = busy; err_at_done = error; end
      end
      if (done_cyc >= 0 && cyc == done_cyc + 3) begin finished = 1; break; end
      if (cyc == poke_cyc) begin
        start = 1; wr_en = 1; wr_addr = 5'($urandom_range(0, 19)); wr_data = $urandom;
      end
      if (!calc_done) result = $urandom;
      case (phase)
        0: begin
          if (rmode == 0)      ready = 1;
          else if (rmode == 1) ready = (cyc % 2 == 1);
          else begin
            ready   = (low_run >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
            low_run = ready ? 0 : low_run + 1;
          end
          if (data_valid && ready) begin
            got.push_back(data); acc_cyc.push_back(cyc);
            if (got.size() == abort_after) begin finished = 1; break; end
            if (got.size() == 20) phase = 1;
          end
        end
        1: begin
          ready = 0;
          if (!no_dd) begin data_done = 1; phase = 2; end
        end
        2: begin
          calc_done = 1; result = res_send[k];
          if (read_done) begin
            if (hold == 0) begin calc_done = 0; gap = $urandom_range(1, 3); phase = 4; end
            else begin hold_left = hold; phase = 3; end
          end
        end
        3: begin
          hold_left--;
          if (hold_left == 0) begin calc_done = 0; gap = $urandom_range(1, 3); phase = 4; end
        end
        4: begin
          gap--;
          if (gap == 0) begin k++; phase = (k < 4) ? 2 : 5; end
        end
        default: ready = 0;
      endcase
    end
    if (abort_after == 0) idle_inputs();
  endtask

  task automatic load_random;
    for (int i = 0; i < 20; i++) write_word(5'(i), $urandom);
    for (int i = 0; i < 4; i++) res_send[i] = $urandom;
  endtask

  task automatic test_reset;
    n_vec++;
    if ({data_valid, data, read_done, busy, done, error} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got dv=%b data=%h rd=%b busy=%b done=%b err=%b required all 0",
                        data_valid, data, read_done, busy, done, error);
    end
    for (int i = 0; i < 4; i++) begin
      res_addr = 2'(i); #1; n_vec++;
      if (res_data !== 32'h0) begin n_err++; $display("FAIL reset_res[%0d]: got %h required 0", i, res_data); end
    end
  endtask

  task automatic test_happy;
    logic [31:0] vec [4];
    vec[0] = 32'h3F800000; vec[1] = 32'h40000000; vec[2] = 32'h40400000; vec[3] = 32'h40800000;
    for (int i = 0; i < 16; i++) write_word(5'(i), (i / 4 == i % 4) ? 32'h3F800000 : 32'h0);
    for (int i = 0; i < 4; i++) begin write_word(5'(16 + i), vec[i]); res_send[i] = vec[i]; end
    run_txn(0, 0, 0, 0, 0, 0);
    n_vec++;
    if (!finished || got.size() != 20) begin
      n_err++; $display("FAIL happy_complete: got finished=%0d words=%0d required 1/20", finished, got.size());
    end
    for (int i = 0; i < got.size() && i < 20; i++) begin
      n_vec++;
      if (got[i] !== op_model[i] || acc_cyc[i] != 1 + i) begin
        n_err++; $display("FAIL happy_word[%0d]: got %h at cycle %0d required %h at cycle %0d",
                          i, got[i], acc_cyc[i], op_model[i], 1 + i);
      end
    end
    n_vec++;
    if (dv_at21 !== 1'b0 || busy_at1 !== 1'b1 || rd_cnt != 4 || done_cnt != 1 ||
        err_at_done !== 1'b0 || busy_at_done !== 1'b0) begin
      n_err++; $display("FAIL happy_ctrl: got dv21=%b busy1=%b rd=%0d done=%0d err=%b busy_done=%b required 0 1 4 1 0 0",
                        dv_at21, busy_at1, rd_cnt, done_cnt, err_at_done, busy_at_done);
    end
    for (int i = 0; i < 4; i++) begin
      res_model[i] = vec[i];
      res_addr = 2'(i); #1; n_vec++;
      if (res_data !== res_model[i]) begin n_err++; $display("FAIL happy_res[%0d]: got %h required %h", i, res_data, res_model[i]); end
    end
  endtask

  task automatic test_backpressure;
    load_random();
    run_txn(1, 0, 0, 0, 0, 0);
    n_vec++;
    if (!finished || got.size() != 20 || rd_cnt != 4 || done_cnt != 1) begin
      n_err++; $display("FAIL bp_counts: got fin=%0d words=%0d rd=%0d done=%0d required 1 20 4 1",
                        finished, got.size(), rd_cnt, done_cnt);
    end
    for (int i = 0; i < got.size() && i < 20; i++) begin
      n_vec++;
      if (got[i] !== op_model[i]) begin n_err++; $display("FAIL bp_word[%0d]: got %h required %h", i, got[i], op_model[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      res_model[i] = res_send[i];
      res_addr = 2'(i); #1; n_vec++;
      if (res_data !== res_model[i]) begin n_err++; $display("FAIL bp_res[%0d]: got %h required %h", i, res_data, res_model[i]); end
    end
  endtask

  task automatic test_slow_release;
    load_random();
    run_txn(2, 3, 0, 0, 0, 0);
    n_vec++;
    if (!finished || rd_cnt != 4 || done_cnt != 1 || err_at_done !== 1'b0) begin
      n_err++; $display("FAIL slow_counts: got fin=%0d rd=%0d done=%0d err=%b required 1 4 1 0",
                        finished, rd_cnt, done_cnt, err_at_done);
    end
    for (int i = 0; i < 4; i++) begin
      res_model[i] = res_send[i];
      res_addr = 2'(i); #1; n_vec++;
      if (res_data !== res_model[i]) begin n_err++; $display("FAIL slow_res[%0d]: got %h required %h", i, res_data, res_model[i]); end
    end
  endtask

  task automatic test_timeout;
    int exp_done;
    load_random();
    run_txn(0, 0, 1, 0, 0, 0);
    exp_done = (acc_cyc.size() == 20) ? acc_cyc[19] + 1 + TMO : -1;
    n_vec++;
    if (!finished || done_cyc != exp_done || done_cnt != 1) begin
      n_err++; $display("FAIL timeout_done_cycle: got %0d (count %0d) required %0d", done_cyc, done_cnt, exp_done);
    end
    n_vec++;
    if (err_at_done !== 1'b1 || busy_at_done !== 1'b0 || rd_cnt != 0) begin
      n_err++; $display("FAIL timeout_flags: got err=%b busy=%b rd=%0d required 1 0 0", err_at_done, busy_at_done, rd_cnt);
    end
    repeat (4) @(negedge clk);
    n_vec++;
    if (error !== 1'b1) begin n_err++; $display("FAIL timeout_sticky: got %b required 1", error); end
    for (int i = 0; i < 4; i++) begin
      res_addr = 2'(i); #1; n_vec++;
      if (res_data !== res_model[i]) begin n_err++; $display("FAIL timeout_res_kept[%0d]: got %h required %h", i, res_data, res_model[i]); end
    end
    for (int i = 0; i < 4; i++) res_send[i] = $urandom;
    run_txn(0, 0, 0, 0, 0, 0);
    n_vec++;
    if (err_at1 !== 1'b0 || err_at_done !== 1'b0 || rd_cnt != 4) begin
      n_err++; $display("FAIL timeout_clear: got err1=%b err_done=%b rd=%0d required 0 0 4", err_at1, err_at_done, rd_cnt);
    end
    for (int i = 0; i < 4; i++) res_model[i] = res_send[i];
  endtask

  task automatic test_reset_mid_send;
    load_random();
    run_txn(0, 0, 0, 8, 0, 0);
    @(posedge clk); #2;
    n_vec++;
    if (data_valid !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL midsend_active: got dv=%b busy=%b required 1 1", data_valid, busy);
    end
    rst_n = 0; #1;
    n_vec++;
    if ({data_valid, data, read_done, busy, done, error} !== '0) begin
      n_err++; $display("FAIL midsend_async_reset: got dv=%b data=%h rd=%b busy=%b done=%b err=%b required all 0",
                        data_valid, data, read_done, busy, done, error);
    end
    idle_inputs();
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 20; i++) op_model[i] = 32'h0;
    for (int i = 0; i < 4; i++) res_model[i] = 32'h0;
    for (int i = 0; i < 4; i++) res_send[i] = $urandom;
    run_txn(0, 0, 0, 0, 0, 0);
    n_vec++;
    if (!finished || got.size() != 20 || rd_cnt != 4) begin
      n_err++; $display("FAIL midsend_resend: got fin=%0d words=%0d rd=%0d required 1 20 4", finished, got.size(), rd_cnt);
    end
    for (int i = 0; i < got.size() && i < 20; i++) begin
      n_vec++;
      if (got[i] !== op_model[i] || acc_cyc[i] != 1 + i) begin
        n_err++; $display("FAIL midsend_word[%0d]: got %h at %0d required %h at %0d", i, got[i], acc_cyc[i], op_model[i], 1 + i);
      end
    end
    for (int i = 0; i < 4; i++) res_model[i] = res_send[i];
  endtask

  task automatic test_ignored;
    for (int t = 0; t < 2; t++) begin
      load_random();
      run_txn(2, 0, 0, 0, (t == 0) ? $urandom_range(2, 12) : $urandom_range(24, 30), 0);
      n_vec++;
      if (!finished || got.size() != 20 || rd_cnt != 4 || done_cnt != 1) begin
        n_err++; $display("FAIL ignored_counts[%0d]: got fin=%0d words=%0d rd=%0d done=%0d required 1 20 4 1",
                          t, finished, got.size(), rd_cnt, done_cnt);
      end
      for (int i = 0; i < got.size() && i < 20; i++) begin
        n_vec++;
        if (got[i] !== op_model[i]) begin n_err++; $display("FAIL ignored_word[%0d]: got %h required %h", i, got[i], op_model[i]); end
      end
      for (int i = 0; i < 4; i++) res_model[i] = res_send[i];
    end
    // A follow-up transaction exposes any operand the ignored write slipped in.
    for (int i = 0; i < 4; i++) res_send[i] = $urandom;
    run_txn(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < got.size() && i < 20; i++) begin
      n_vec++;
      if (got[i] !== op_model[i]) begin n_err++; $display("FAIL ignored_file[%0d]: got %h required %h", i, got[i], op_model[i]); end
    end
    for (int i = 0; i < 4; i++) res_model[i] = res_send[i];
  endtask

  task automatic test_random;
    for (int t = 0; t < 4; t++) begin
      load_random();
      write_word(5'($urandom_range(20, 31)), $urandom);
      run_txn($urandom_range(0, 2), $urandom_range(0, 3), 0, 0, 0, 1);
      n_vec++;
      if (!finished || got.size() != 20 || rd_cnt != 4 || done_cnt != 1 || err_at_done !== 1'b0) begin
        n_err++; $display("FAIL random_counts[%0d]: got fin=%0d words=%0d rd=%0d done=%0d err=%b required 1 20 4 1 0",
                          t, finished, got.size(), rd_cnt, done_cnt, err_at_done);
      end
      for (int i = 0; i < got.size() && i < 20; i++) begin
        n_vec++;
        if (got[i] !== op_model[i]) begin n_err++; $display("FAIL random_word[%0d.%0d]: got %h required %h", t, i, got[i], op_model[i]); end
      end
      for (int i = 0; i < 4; i++) begin
        res_model[i] = res_send[i];
        res_addr = 2'(i); #1; n_vec++;
        if (res_data !== res_model[i]) begin n_err++; $display("FAIL random_res[%0d.%0d]: got %h required %h", t, i, res_data, res_model[i]); end
      end
    end
  endtask

  initial begin
    rst_n = 0; wr_addr = '0; wr_data = '0; result = '0; res_addr = '0;
    idle_inputs();
    for (int i = 0; i < 20; i++) op_model[i] = 32'h0;
    for (int i = 0; i < 4; i++) begin res_model[i] = 32'h0; res_send[i] = 32'h0; end
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    test_reset();
    test_happy();
    test_backpressure();
    test_slow_release();
    test_timeout();
    test_reset_mid_send();
    test_ignored();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mv_stream_driver.md
# mv_stream_driver

Initiator for the matrix-vector accelerator's word-serial protocol (ready / data_valid / data / data_done / calc_done / result / read_done). The block holds a host-loaded 4x4 matrix and 4x1 vector in a 20-word register file. On start it streams the 20 words into the accelerator, collects the 4 result words with per-word acknowledge, and exposes them to the host. It sits between the pipeline control logic and the mul4x4_4x1 datapath instance.

## Interface
- TIMEOUT, 1024: maximum cycles spent in any wait state before aborting with error.
- iClk  in  1  clock; all logic is rising-edge.
- iRstn  in  1  asynchronous, active-low reset.
- wr_en  in  1  host write strobe into the operand file; ignored while busy.
- wr_addr  in  5  operand index: 0–15 matrix row-major (row*4+col), 16–19 vector; values 20–31 are ignored.
- wr_data  in  32  IEEE-754 single operand.
- start  in  1  one-cycle pulse that launches a transaction; ignored while busy.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at the end of a transaction (success or error).
- error  out  1  sticky timeout flag; cleared by the next accepted start.
- res_addr  in  2  result read index.
- res_data  out  32  combinational read of result register res_addr.
- ready  in  1  accelerator can accept a word.
- data_valid  out  1  word on data is valid.
- data  out  32  operand word to the accelerator.
- data_done  in  1  accelerator has received all 20 words.
- calc_done  in  1  accelerator presents a valid result.
- result  in  32  result word, valid while calc_done is high.
- read_done  out  1  one-cycle acknowledge that the current result was captured.

## Operation
- States: IDLE, SEND, WAIT_DD, CAPTURE, ACK, RELEASE, FINISH.
- IDLE
  - start=1 → SEND.
  - Clears send index, result index, timeout counter and error.
- SEND
  - data_valid=1; data=opfile[send_idx].
  - A word is accepted on a cycle with data_valid & ready. On acceptance, send_idx increments.
  - When ready=0, data and data_valid hold.
  - After word 19 is accepted → WAIT_DD, with data_valid low in the next cycle.
- WAIT_DD: data_done=1 → CAPTURE.
- CAPTURE: calc_done=1 → res[res_idx]←result, then → ACK.
- ACK
  - read_done=1 for exactly one cycle.
  - res_idx increments.
  - → RELEASE.
- RELEASE
  - Waits for calc_done=0.
  - Then → CAPTURE if res_idx<4, else → FINISH.
  - This prevents double capture of one result.
- FINISH: done=1 for one cycle, busy=0, → IDLE.
- Timeout
  - The counter resets on every state change and on every accepted word.
  - It increments in SEND (only while ready=0), WAIT_DD, CAPTURE and RELEASE.
  - On reaching TIMEOUT: error←1, data_valid←0, → FINISH.
  - Results captured so far are kept; uncaptured entries keep their old values.
- data_done seen outside WAIT_DD and calc_done seen outside CAPTURE/RELEASE are ignored.
- The operand file and results persist across transactions. Host writes in IDLE take effect next cycle; a write and a start in the same cycle both take effect, and the written value is sent.
- The block does no arithmetic; words pass bit-exact.

## Timing
- Reset values
  - All outputs 0: data_valid, data, read_done, busy, done, error.
  - res_data reads 0 because all result registers reset to 0.
  - The operand file resets to 0.
- Reset asserted mid-transaction aborts immediately to IDLE with the reset values. No read_done or done is issued.
- Send latency
  - start at cycle 0 → data_valid=1 with word 0 at cycle 1.
  - With ready held high, word k is on data at cycle 1+k and word 19 at cycle 20.
  - data_valid=0 at cycle 21.
- Capture timing
  - calc_done sampled high in CAPTURE at cycle c → read_done high at c+1 only.
  - res_data reflects the new value from c+1.
- done follows the final RELEASE exit by one cycle. busy falls in the same cycle done is high.

## Test plan
- Happy path:
  - Stimulus: load identity matrix, vector {1.0,2.0,3.0,4.0} (0x3F800000, 0x40000000, 0x40400000, 0x40800000); ready tied high; model returns the vector.
  - Required: 20 words on cycles 1–20 in index order; 4 read_done pulses; res[0..3]=0x3F800000..0x40800000; done once; error=0.
- Backpressure:
  - Stimulus: ready low on alternate cycles during SEND.
  - Required: each word is held until accepted; none skipped or duplicated; exactly 20 accepted.
- Slow result release:
  - Stimulus: model keeps calc_done high 3 cycles after read_done.
  - Required: exactly one capture per result; exactly 4 read_done pulses total.
- Timeout:
  - Stimulus: TIMEOUT=16; data_done never asserted.
  - Required: error=1 and a done pulse 16 cycles after entering WAIT_DD; busy=0; next start clears error.
- Reset mid-send:
  - Stimulus: iRstn low after word 7.
  - Required: all outputs 0 asynchronously; after release, a start re-sends from word 0 with the operand file zeroed.
- Ignored inputs:
  - Stimulus: start and wr_en asserted while busy.
  - Required: no restart; operand file unchanged; the transaction completes normally.
